// File: rtl/cordic_atan2_pkg.sv
// Shared constants, arctangent table and pipeline stage record for the
// vectoring-mode CORDIC (cordic_atan2). Angles use 14 fractional bits.
package cordic_atan2_pkg;

  localparam int FRAC_BITS  = 14;
  localparam int STAGE_IW   = 20;
  localparam int MAX_STAGES = 16;

  localparam logic signed [31:0] PI      = 32'sd51472;
  localparam logic signed [31:0] HALF_PI = 32'sd25736;
  localparam logic signed [15:0] INV_K   = 16'sd9949;

  // round(atan(2^-i) * 2^14)
  localparam logic signed [31:0] ATAN [0:MAX_STAGES-1] = '{
    32'sd12868, 32'sd7596, 32'sd4014, 32'sd2037,
    32'sd1023,  32'sd512,  32'sd256,  32'sd128,
    32'sd64,    32'sd32,   32'sd16,   32'sd8,
    32'sd4,     32'sd2,    32'sd1,    32'sd0
  };

  // One sample in flight: qualifier, zero-vector flag, vector and angle.
  typedef struct packed {
    logic                       valid;
    logic                       zero;
    logic signed [STAGE_IW-1:0] x;
    logic signed [STAGE_IW-1:0] y;
    logic signed [31:0]         z;
  } stage_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation with shift index SHIFT.
// The rotation direction is chosen to drive y towards zero.
module cordic_vec_stage
  import cordic_atan2_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic   clock,
  input  logic   reset,
  input  stage_t src,
  output stage_t dst
);

  logic signed [STAGE_IW-1:0] x_cur;
  logic signed [STAGE_IW-1:0] y_cur;
  logic signed [STAGE_IW-1:0] x_sh;
  logic signed [STAGE_IW-1:0] y_sh;
  stage_t                     stage_next;

  // Micro-rotation; both updates use the previous-stage x and y.
  always_comb begin
    x_cur      = src.x;
    y_cur      = src.y;
    x_sh       = x_cur >>> SHIFT;
    y_sh       = y_cur >>> SHIFT;
    stage_next = src;
    if (!y_cur[STAGE_IW-1]) begin
      stage_next.x = x_cur + y_sh;
      stage_next.y = y_cur - x_sh;
      stage_next.z = src.z + ATAN[SHIFT];
    end else begin
      stage_next.x = x_cur - y_sh;
      stage_next.y = y_cur + x_sh;
      stage_next.z = src.z - ATAN[SHIFT];
    end
  end

  // Stage register, cleared by reset so nothing stale survives it.
  always_ff @(posedge clock) begin
    if (reset) dst <= '0;
    else       dst <= stage_next;
  end

endmodule

// File: rtl/cordic_atan2.sv
// Pipelined vectoring CORDIC: (x, y) in Q1.14 -> atan2(y, x) with 14
// fractional bits in (-pi, pi] plus vector magnitude.
// Optional macro MAG_COMP_EN: adds a 1/K multiply stage so mag_out is the
// true magnitude (latency STAGES+3 instead of STAGES+2).
module cordic_atan2
  import cordic_atan2_pkg::*;
#(
  parameter int STAGES    = 16,
  parameter int FRAC_BITS = 14,
  parameter int IW        = 20
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic signed [FRAC_BITS+1:0] x_in,
  input  logic signed [FRAC_BITS+1:0] y_in,
  output logic                        valid_out,
  output logic signed [31:0]          rad_out,
  output logic        [17:0]          mag_out
);

  localparam logic signed [STAGE_IW-1:0] MAG_MAX = STAGE_IW'(18'h3ffff);

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  stage_t               pre_next;
  stage_t               pre_reg;
  stage_t               chain [0:STAGES];
  stage_t               fin;
  stage_t               tail;

  // Pre-rotation into the right half-plane; sign-extend first so that
  // negating -32768 cannot overflow.
  always_comb begin
    x_ext          = IW'(x_in);
    y_ext          = IW'(y_in);
    pre_next.valid = valid_in;
    pre_next.zero  = (x_in == '0) && (y_in == '0);
    if (!x_in[FRAC_BITS+1]) begin
      pre_next.x = x_ext;
      pre_next.y = y_ext;
      pre_next.z = '0;
    end else if (!y_in[FRAC_BITS+1]) begin
      pre_next.x = y_ext;
      pre_next.y = -x_ext;
      pre_next.z = HALF_PI;
    end else begin
      pre_next.x = -y_ext;
      pre_next.y = x_ext;
      pre_next.z = -HALF_PI;
    end
  end

  // Pre-rotation register.
  always_ff @(posedge clock) begin
    if (reset) pre_reg <= '0;
    else       pre_reg <= pre_next;
  end

  assign chain[0] = pre_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      cordic_vec_stage #(.SHIFT(gi)) u_stage (
        .clock (clock),
        .reset (reset),
        .src   (chain[gi]),
        .dst   (chain[gi+1])
      );
    end
  endgenerate

  assign fin = chain[STAGES];

`ifdef MAG_COMP_EN
  localparam logic signed [39:0] ROUND_HALF = 40'sd1 <<< (FRAC_BITS - 1);

  logic signed [STAGE_IW-1:0] fin_x;
  logic signed [39:0]         prod;
  stage_t                     comp_next;
  stage_t                     comp_reg;
  logic                       unused_bits;

  // Scale the raw CORDIC x by 1/K with round-to-nearest; angle rides along.
  always_comb begin
    fin_x       = fin.x;
    prod        = 40'(fin_x) * 40'(INV_K) + ROUND_HALF;
    comp_next   = fin;
    comp_next.x = STAGE_IW'(prod >>> FRAC_BITS);
    comp_next.y = '0;
  end

  // Compensation register.
  always_ff @(posedge clock) begin
    if (reset) comp_reg <= '0;
    else       comp_reg <= comp_next;
  end

  assign tail        = comp_reg;
  assign unused_bits = ^{fin.y, comp_reg.y};
`else
  logic unused_bits;

  assign tail        = fin;
  assign unused_bits = ^fin.y;
`endif

  logic signed [STAGE_IW-1:0] tail_x;
  logic signed [31:0]         rad_next;
  logic        [17:0]         mag_next;

  // Final formatting: fold -pi onto +pi, saturate magnitude, zero vector -> 0.
  always_comb begin
    tail_x   = tail.x;
    rad_next = (tail.z == -PI) ? PI : tail.z;
    if (tail_x < 0)            mag_next = '0;
    else if (tail_x > MAG_MAX) mag_next = '1;
    else                       mag_next = tail_x[17:0];
    if (tail.zero) begin
      rad_next = '0;
      mag_next = '0;
    end
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      rad_out   <= '0;
      mag_out   <= '0;
    end else begin
      valid_out <= tail.valid;
      rad_out   <= rad_next;
      mag_out   <= mag_next;
    end
  end

endmodule

// File: doc/cordic_atan2.md
Name: cordic_atan2

Overview:
Vectoring-mode CORDIC, the inverse of the rotation-mode sin/cos engine. It takes a (cos, sin) pair and returns the angle atan2(sin, cos) in radians, plus the vector magnitude.
- Input format matches the engine's sin_out/cos_out: Q1.14, 16-bit signed.
- Angle output format matches the engine's rad_in: 32-bit signed, 14 fractional bits.
- Fully pipelined, one sample per clock, valid-only streaming with no backpressure.
- Used for round-trip checking and as a phase-recovery stage downstream of the sin/cos engine.

Parameters:
- STAGES, 16, number of micro-rotation iterations (1..16).
- FRAC_BITS, 14, fractional bits of x/y inputs and rad_out.
- IW, 20, internal x/y datapath width (sign + growth + guard).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  x_in/y_in qualify this cycle
- x_in  in  16  signed cosine component, Q1.14
- y_in  in  16  signed sine component, Q1.14
- valid_out  out  1  rad_out/mag_out valid this cycle
- rad_out  out  32  signed angle, 14 frac bits, range (-pi, pi]
- mag_out  out  18  unsigned magnitude (scaling per MAG_COMP_EN)

Behaviour:
- Interface: one clock, named clock; reset named reset, synchronous and active-high.
- Reset: every pipeline valid bit and every output clears to 0 on the edge where reset=1. Data registers also clear.
- Reset mid-stream: all in-flight samples are dropped. valid_out stays 0 until a sample accepted after reset has traversed the pipe.
- Latency L = STAGES+2 (18 by default). A sample with valid_in=1 at edge k appears with valid_out=1 after edge k+L.
- Throughput is one sample per cycle. Bubbles in valid_in propagate unchanged. Data registers may update when invalid; the bench checks outputs only when valid_out=1.
- Stage P (pre-rotation, 1 cycle):
  - Sign-extend x/y to IW before any negation, so -32768 is safe.
  - x>=0: pass through, z=0.
  - x<0, y>=0: x'=y, y'=-x, z=+pi/2 (25736).
  - x<0, y<0: x'=-y, y'=x, z=-pi/2 (-25736).
- Stage P also computes zero_flag = (x_in==0 && y_in==0). zero_flag travels with the sample.
- Iteration stage i (i=0..STAGES-1, 1 cycle each), with shifts arithmetic:
  - y>=0: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
  - y<0: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
  - Both x and y updates use the previous-stage values. y==0 takes the y>=0 branch.
- Output register (1 cycle):
  - If zero_flag: rad_out=0, mag_out=0.
  - Otherwise: rad_out=z sign-extended to 32 bits.
  - If z == -pi after rounding, output +51472 so the range is (-pi, pi].
  - mag_out = final x (never negative after pre-rotation), saturated to 18 bits.
- Accuracy for |vector| >= 4096 LSB: |rad_out error| <= 4 LSB, |mag_out error| <= 4 LSB of the ideal scaled value.

Optional Feature:
MAG_COMP_EN
- Defined: adds one multiply stage that scales the final x by 1/K = 9949 (Q0.14), rounds, and shifts right by 14. mag_out is then the true magnitude.
  - Latency becomes STAGES+3.
  - rad_out and zero_flag are delayed to stay aligned with mag_out.
- Undefined: mag_out is raw x, approximately 1.64676 x |v|. Latency is STAGES+2. No multiplier is inferred.

Decomposition:
- Package cordic_atan2_pkg:
  - FRAC_BITS.
  - PI (51472), HALF_PI (25736), INV_K (9949).
  - ATAN table: 16 x 32-bit signed, round(atan(2^-i) * 2^14), for example 12868, 7596, 4014, 2037, ...
  - Stage struct typedef {logic valid; logic zero; logic signed [IW-1:0] x, y; logic signed [31:0] z;}.
- Sub-module cordic_vec_stage:
  - Parameterised on shift index i.
  - One registered micro-rotation on the stage struct.
  - Instantiated STAGES times by a generate loop.

Test Plan:
- x=16384, y=0 -> rad_out 0±4; mag_out 16384±4 with MAG_COMP_EN, 26981±4 without; appears exactly L cycles after input.
- x=0, y=16384 -> rad_out 25736±4. Then x=0, y=-16384 -> rad_out -25736±4.
- x=-16384, y=0 -> rad_out +51472±4 (positive pi). x=-16384, y=-1 -> rad_out ≈ -51471, never positive.
- x=11585, y=11585 -> rad_out 12868±4, compensated mag 16384±4. x=y=0 -> rad_out 0, mag_out 0. x=-32768, y=-32768 -> rad_out ≈ -38604±4, no overflow.
- Stream 200 random samples with random valid bubbles, feeding back sin_out/cos_out from the rotation engine for angles in (-pi, pi] -> output count equals input count, order preserved, rad_out matches the original angle ±4.
- Assert reset for 1 cycle mid-stream with 10 samples in flight -> valid_out=0 and outputs 0 on the next cycle. No stale sample is ever emitted. The first post-reset sample appears exactly L cycles after it is accepted.
